// File: rtl/cw_trace_buffer.sv
// cw_trace_buffer: trace sample store for the on-chip watcher.
//
// Captures the watcher write port into a circular RAM while wt_ce is high.
// After the window closes it streams the stored samples oldest-first over a
// valid/ready port.
//
// Ports:
//   trig_clk, trig_rst        clock, synchronous active-high reset
//   wt_ce, wt_en, wt_addr     watcher write port (wt_addr[ADDR_W-1:0] used)
//   din                       sample word, qualified by wt_en
//   clear                     discard contents, back to IDLE (top priority)
//   rd_start                  begin readout from DONE
//   rd_valid/rd_ready         readout handshake; rd_data, rd_last per beat
//   count                     stored samples, saturating at 2^ADDR_W
//   done, busy, ovf           status; ovf = write dropped during READ
//
// Optional macro CW_TRACE_TIMESTAMP_EN: stores a 16-bit capture-relative
// cycle stamp next to each sample and adds the rd_ts output.
module cw_trace_buffer #(
    parameter int DATA_W = 40,
    parameter int ADDR_W = 10
) (
    input  logic              trig_clk,
    input  logic              trig_rst,
    input  logic              wt_ce,
    input  logic              wt_en,
    input  logic [15:0]       wt_addr,
    input  logic [DATA_W-1:0] din,
    input  logic              clear,
    input  logic              rd_start,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              busy,
    output logic              ovf
`ifdef CW_TRACE_TIMESTAMP_EN
    ,
    output logic [15:0]       rd_ts
`endif
);

`ifdef CW_TRACE_TIMESTAMP_EN
    localparam int MEM_W = DATA_W + 16;
`else
    localparam int MEM_W = DATA_W;
`endif
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {IDLE, CAPTURE, DONE, READ} state_t;
    state_t state, state_nx;

    logic [MEM_W-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] idx, first_addr, last_addr, rd_ptr;
    logic [ADDR_W:0]   rd_left;
    logic [MEM_W-1:0]  wr_word, out_word, skid_word;
    logic              out_last, skid_vld, skid_last;
    logic              wr_req, cap_entry, wr_acc, rd_go, pop, issue;
    logic              unused_addr_bits;

    assign idx              = wt_addr[ADDR_W-1:0];
    assign unused_addr_bits = ^wt_addr[15:ADDR_W];
    assign wr_req    = wt_ce & wt_en;
    // The cycle that opens a window is its first capture cycle.
    assign cap_entry = !clear && wt_ce && (state == IDLE || state == DONE);
    assign wr_acc    = !clear && wr_req && (state == CAPTURE || cap_entry);
    assign rd_go     = !clear && state == DONE && !wt_ce && rd_start && count != '0;
    assign pop       = rd_valid & rd_ready;
    // RAM reads land straight in the output/skid registers; fetching only
    // while the skid slot is free keeps rd_ready off the RAM address path.
    assign issue     = state == READ && rd_left != '0 && !skid_vld;

    assign done    = state == DONE;
    assign busy    = state == CAPTURE || state == READ;
    assign rd_data = out_word[DATA_W-1:0];
    assign rd_last = out_last;

`ifdef CW_TRACE_TIMESTAMP_EN
    logic [15:0] ts_cnt;
    assign rd_ts   = out_word[MEM_W-1:DATA_W];
    assign wr_word = {(cap_entry ? 16'd0 : ts_cnt), din};

    always_ff @(posedge trig_clk) begin
        if (trig_rst)       ts_cnt <= '0;
        else if (cap_entry) ts_cnt <= 16'd1;
        else                ts_cnt <= ts_cnt + 16'd1;
    end
`else
    assign wr_word = din;
`endif

    always_ff @(posedge trig_clk) begin
        if (trig_rst) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (clear) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (wt_ce) state_nx = CAPTURE;
                CAPTURE: if (!wt_ce) state_nx = DONE;
                DONE: begin
                    if (wt_ce)                          state_nx = CAPTURE;
                    else if (rd_start && count != '0)   state_nx = READ;
                end
                READ:    if (pop && out_last) state_nx = DONE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge trig_clk) begin
        if (wr_acc) mem[idx] <= wr_word;
    end

    always_ff @(posedge trig_clk) begin
        if (trig_rst) begin
            count      <= '0;
            ovf        <= 1'b0;
            first_addr <= '0;
            last_addr  <= '0;
            rd_ptr     <= '0;
            rd_left    <= '0;
            rd_valid   <= 1'b0;
            out_word   <= '0;
            out_last   <= 1'b0;
            skid_vld   <= 1'b0;
            skid_last  <= 1'b0;
            skid_word  <= '0;
        end else if (clear) begin
            count    <= '0;
            ovf      <= 1'b0;
            rd_left  <= '0;
            rd_valid <= 1'b0;
            out_last <= 1'b0;
            skid_vld <= 1'b0;
        end else begin
            if (cap_entry)
                count <= wr_acc ? (ADDR_W+1)'(1) : '0;
            else if (wr_acc && count != DEPTH_C)
                count <= count + 1'b1;

            if (wr_acc) begin
                last_addr <= idx;
                if (cap_entry || count == '0) first_addr <= idx;
            end

            if (state == READ && wr_req) ovf <= 1'b1;

            // Oldest sample: first write unless the ring has wrapped.
            if (rd_go) begin
                rd_ptr  <= (count < DEPTH_C) ? first_addr : last_addr + 1'b1;
                rd_left <= count;
            end else if (issue) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_left <= rd_left - 1'b1;
            end

            if (!rd_valid || pop) begin
                if (skid_vld) begin
                    out_word <= skid_word;
                    out_last <= skid_last;
                    rd_valid <= 1'b1;
                    skid_vld <= 1'b0;
                end else if (issue) begin
                    out_word <= mem[rd_ptr];
                    out_last <= rd_left == (ADDR_W+1)'(1);
                    rd_valid <= 1'b1;
                end else begin
                    rd_valid <= 1'b0;
                    out_last <= 1'b0;
                end
            end else if (issue) begin
                skid_word <= mem[rd_ptr];
                skid_last <= rd_left == (ADDR_W+1)'(1);
                skid_vld  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cw_trace_buffer.sv
// Bench for cw_trace_buffer (ADDR_W=3, depth 8). Stimulus pushes expected
// beats into a queue; a negedge monitor pops and compares every accepted beat
// and checks that a stalled beat stays put.
module tb_cw_trace_buffer;
    localparam int DATA_W = 40;
    localparam int ADDR_W = 3;

    logic              trig_clk = 1'b0;
    logic              trig_rst, wt_ce, wt_en, clear, rd_start, rd_ready;
    logic [15:0]       wt_addr;
    logic [DATA_W-1:0] din;
    logic              rd_valid, rd_last, done, busy, ovf;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W:0]   count;
`ifdef CW_TRACE_TIMESTAMP_EN
    logic [15:0]       rd_ts;
`endif

    cw_trace_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .trig_clk(trig_clk), .trig_rst(trig_rst), .wt_ce(wt_ce), .wt_en(wt_en),
        .wt_addr(wt_addr), .din(din), .clear(clear), .rd_start(rd_start),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .rd_last(rd_last), .count(count), .done(done), .busy(busy), .ovf(ovf)
`ifdef CW_TRACE_TIMESTAMP_EN
        , .rd_ts(rd_ts)
`endif
    );

    always #5 trig_clk = ~trig_clk;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
        logic              has_ts;
        logic [15:0]       ts;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   beats  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge trig_clk);
        #1;
    endtask

    task automatic push(input logic [DATA_W-1:0] d, input logic l,
                        input logic h, input logic [15:0] t);
        exp_t e;
        e.data = d; e.last = l; e.has_ts = h; e.ts = t;
        sb.push_back(e);
    endtask

    // Monitor: compare accepted beats, and hold-stability of stalled beats.
    logic              hold_pend = 1'b0;
    logic [DATA_W-1:0] hold_data;
    always @(negedge trig_clk) begin
        exp_t e;
        if (trig_rst) begin
            hold_pend = 1'b0;
        end else if (rd_valid) begin
            if (hold_pend) chk("hold_stable", 64'(rd_data), 64'(hold_data));
            if (rd_ready) begin
                beats++;
                hold_pend = 1'b0;
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL extra_beat: got data 0x%0h, expected no beat", rd_data);
                end else begin
                    e = sb.pop_front();
                    chk("beat_data", 64'(rd_data), 64'(e.data));
                    chk("beat_last", 64'(rd_last), 64'(e.last));
`ifdef CW_TRACE_TIMESTAMP_EN
                    if (e.has_ts) chk("beat_ts", 64'(rd_ts), 64'(e.ts));
`endif
                end
            end else begin
                hold_pend = 1'b1;
                hold_data = rd_data;
            end
        end else begin
            if (hold_pend) begin
                checks++; errors++;
                $display("FAIL beat_dropped: valid fell to 0, expected held beat 0x%0h", hold_data);
            end
            hold_pend = 1'b0;
        end
    end

    // Open the window with one idle cycle, then n writes at a0+i / dbase+i.
    task automatic capture(input int n, input logic [15:0] a0, input logic [DATA_W-1:0] dbase);
        wt_ce = 1'b1; wt_en = 1'b0;
        tick();
        chk("cap_busy", 64'(busy), 64'd1);
        for (int i = 0; i < n; i++) begin
            wt_en = 1'b1; wt_addr = a0 + 16'(i); din = dbase + DATA_W'(i);
            tick();
        end
        wt_ce = 1'b0;
        wt_en = 1'b1;   // write in the closing cycle must be ignored
        wt_addr = a0; din = '1;
        chk("cap_done_lo", 64'(done), 64'd0);
        tick();
        wt_en = 1'b0;
        chk("cap_done_hi", 64'(done), 64'd1);
    endtask

    // mode 0: rd_ready high, no bubbles; 1: ready pattern 1,0,0,1;
    // 2: stalled, write strobe mid-READ, then drain.
    task automatic readout(input int n, input int mode);
        logic [3:0] pat;
        pat = 4'b1001;
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        chk("lat_cycle1", 64'(rd_valid), 64'd0);
        tick();
        chk("lat_cycle2", 64'(rd_valid), 64'd1);
        if (mode == 0) begin
            for (int i = 0; i < n; i++) begin
                chk("no_bubble", 64'(rd_valid), 64'd1);
                tick();
            end
        end else begin
            if (mode == 2) begin
                wt_ce = 1'b1; wt_en = 1'b1; wt_addr = 16'd2; din = 40'hBAD;
                tick();
                wt_ce = 1'b0; wt_en = 1'b0;
                chk("ovf_set", 64'(ovf), 64'd1);
                chk("read_busy", 64'(busy), 64'd1);
                rd_ready = 1'b1;
            end
            for (int c = 0; c < 200 && !done; c++) begin
                if (mode == 1) rd_ready = pat[c % 4];
                tick();
            end
            rd_ready = 1'b1;
        end
        chk("read_done", 64'(done), 64'd1);
        chk("sb_drained", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int b0;
        logic seen;
        trig_rst = 1'b1; wt_ce = 1'b0; wt_en = 1'b0; wt_addr = '0; din = '0;
        clear = 1'b0; rd_start = 1'b0; rd_ready = 1'b1;
        repeat (3) tick();
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_rd_data",  64'(rd_data),  64'd0);
        chk("rst_rd_last",  64'(rd_last),  64'd0);
        chk("rst_count",    64'(count),    64'd0);
        chk("rst_done",     64'(done),     64'd0);
        chk("rst_busy",     64'(busy),     64'd0);
        chk("rst_ovf",      64'(ovf),      64'd0);
        trig_rst = 1'b0;
        tick();

        // 5 samples, full-rate readout
        capture(5, 16'd0, 40'h100);
        chk("count5", 64'(count), 64'd5);
        for (int i = 0; i < 5; i++) push(40'h100 + 40'(i), i == 4, 1'b0, 16'd0);
        readout(5, 0);

        // wrap: 11 writes into depth 8, oldest is wt_addr 3
        capture(11, 16'd0, 40'h0);
        chk("count_sat", 64'(count), 64'd8);
        for (int i = 3; i <= 10; i++) push(40'(i), i == 10, 1'b0, 16'd0);
        readout(8, 0);

        // backpressure
        capture(4, 16'd2, 40'h200);
        for (int i = 0; i < 4; i++) push(40'h200 + 40'(i), i == 3, 1'b0, 16'd0);
        readout(4, 1);

        // write during READ is dropped and flagged
        chk("ovf_pre", 64'(ovf), 64'd0);
        capture(3, 16'd0, 40'h300);
        rd_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(40'h300 + 40'(i), i == 2, 1'b0, 16'd0);
        readout(3, 2);
        chk("ovf_sticky", 64'(ovf), 64'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_ovf",   64'(ovf),   64'd0);
        chk("clr_count", 64'(count), 64'd0);
        chk("clr_done",  64'(done),  64'd0);
        chk("clr_busy",  64'(busy),  64'd0);

        // empty window: rd_start ignored
        capture(0, 16'd0, 40'h0);
        chk("count0", 64'(count), 64'd0);
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (rd_valid) seen = 1'b1;
            tick();
        end
        chk("empty_no_valid", 64'(seen), 64'd0);
        chk("empty_done",     64'(done), 64'd1);

        // clear after two accepted beats
        capture(5, 16'd0, 40'h400);
        for (int i = 0; i < 5; i++) push(40'h400 + 40'(i), i == 4, 1'b0, 16'd0);
        b0 = beats;
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        tick();
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_rd_valid", 64'(rd_valid), 64'd0);
        chk("clr_mid_count", 64'(count), 64'd0);
        chk("clr_beats", 64'(beats - b0), 64'd2);
        sb.delete();
        tick();
        chk("clr_idle", 64'(busy | done), 64'd0);

`ifdef CW_TRACE_TIMESTAMP_EN
        // writes on capture cycles 0, 3, 4
        wt_ce = 1'b1;
        for (int c = 0; c < 5; c++) begin
            wt_en = (c == 0 || c == 3 || c == 4);
            wt_addr = 16'(c); din = 40'h500 + 40'(c);
            tick();
        end
        wt_ce = 1'b0; wt_en = 1'b0;
        tick();
        chk("ts_count", 64'(count), 64'd3);
        push(40'h500, 1'b0, 1'b1, 16'd0);
        push(40'h503, 1'b0, 1'b1, 16'd3);
        push(40'h504, 1'b1, 1'b1, 16'd4);
        readout(3, 0);
`endif

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
